// File: rtl/bus_arbiter_if.sv
// Two-master / two-slave bus bundle for bus_arbiter.
// The arbiter modport is the arbiter's own view; master and slave are the agent-side views.
interface bus_arbiter_if;
    logic       M0_req;
    logic       M0_wr;
    logic [7:0] M0_address;
    logic [7:0] M0_dout;
    logic       M1_req;
    logic       M1_wr;
    logic [7:0] M1_address;
    logic [7:0] M1_dout;
    logic       M0_grant;
    logic       M1_grant;
    logic [7:0] M_din;
    logic       bus_error;
    logic       S0_sel;
    logic       S1_sel;
    logic [7:0] S_address;
    logic       S_wr;
    logic [7:0] S_din;
    logic [7:0] S0_dout;
    logic [7:0] S1_dout;

    modport arbiter (
        input  M0_req, M0_wr, M0_address, M0_dout,
        input  M1_req, M1_wr, M1_address, M1_dout,
        input  S0_dout, S1_dout,
        output M0_grant, M1_grant, M_din, bus_error,
        output S0_sel, S1_sel, S_address, S_wr, S_din
    );

    modport master (
        output M0_req, M0_wr, M0_address, M0_dout,
        output M1_req, M1_wr, M1_address, M1_dout,
        input  M0_grant, M1_grant, M_din, bus_error
    );

    modport slave (
        input  S0_sel, S1_sel, S_address, S_wr, S_din,
        output S0_dout, S1_dout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with parked grant, address decode and read-data return.
// Optional contended-hold timeout with forced switch and bus_error pulse: define BUS_TIMEOUT_EN.
module bus_arbiter #(
    parameter logic [7:0] S0_BASE        = 8'h00,
    parameter logic [7:0] S1_BASE        = 8'h20,
    parameter logic [7:0] DEC_MASK       = 8'hE0,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic           clk,
    input logic           reset,
    bus_arbiter_if.arbiter bus
);
    localparam logic [0:0] GNT_M0 = 1'b0;
    localparam logic [0:0] GNT_M1 = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_next;
    logic       w_own_m0;
    logic       w_req;
    logic       w_wr;
    logic [7:0] w_addr;
    logic [7:0] w_dout;
    logic       w_hit0;
    logic       w_hit1;
    logic       w_sel0;
    logic       w_sel1;

    assign w_own_m0 = (r_state == GNT_M0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            GNT_M0:  if (!bus.M0_req && bus.M1_req) w_next = GNT_M1;
            GNT_M1:  if (!bus.M1_req && bus.M0_req) w_next = GNT_M0;
            default: w_next = GNT_M0;
        endcase
    end

    assign w_req  = w_own_m0 ? bus.M0_req     : bus.M1_req;
    assign w_wr   = w_own_m0 ? bus.M0_wr      : bus.M1_wr;
    assign w_addr = w_own_m0 ? bus.M0_address : bus.M1_address;
    assign w_dout = w_own_m0 ? bus.M0_dout    : bus.M1_dout;

    // Slave 0 wins if the two decode windows are ever configured to overlap.
    assign w_hit0 = ((w_addr & DEC_MASK) == S0_BASE);
    assign w_hit1 = ((w_addr & DEC_MASK) == S1_BASE);
    assign w_sel0 = w_req & w_hit0;
    assign w_sel1 = w_req & w_hit1 & ~w_hit0;

    assign bus.M0_grant  = w_own_m0;
    assign bus.M1_grant  = ~w_own_m0;
    assign bus.S_address = w_addr;
    assign bus.S_din     = w_dout;
    assign bus.S_wr      = w_req & w_wr;
    assign bus.S0_sel    = w_sel0;
    assign bus.S1_sel    = w_sel1;
    assign bus.M_din     = w_sel0 ? bus.S0_dout : (w_sel1 ? bus.S1_dout : 8'h00);

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          w_contend;

    assign w_contend     = w_req & (w_own_m0 ? bus.M1_req : bus.M0_req);
    assign bus.bus_error = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= GNT_M0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_contend && (r_cnt == CW'(TIMEOUT_CYCLES - 1))) begin
                r_state <= ~r_state;
                r_cnt   <= '0;
                r_err   <= 1'b1;
            end else begin
                r_state <= w_next;
                r_cnt   <= w_contend ? r_cnt + 1'b1 : '0;
            end
        end
    end
`else
    assign bus.bus_error = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= GNT_M0;
        else       r_state <= w_next;
    end
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: vector table plus reset, timeout and async-reset sequences.
module tb_bus_arbiter;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    bus_arbiter_if bif ();

    bus_arbiter #(
        .S0_BASE       (8'h00),
        .S1_BASE       (8'h20),
        .DEC_MASK      (8'hE0),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       m0_req;
        logic       m0_wr;
        logic [7:0] m0_addr;
        logic [7:0] m0_dout;
        logic       m1_req;
        logic       m1_wr;
        logic [7:0] m1_addr;
        logic [7:0] m1_dout;
        logic [7:0] s0_dout;
        logic [7:0] s1_dout;
        // expected after the next rising edge: {g0,g1,s0,s1,wr}, addr, din, mdin
        logic [4:0] e_ctl;
        logic [7:0] e_addr;
        logic [7:0] e_din;
        logic [7:0] e_mdin;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bif.M0_req     = v.m0_req;
        bif.M0_wr      = v.m0_wr;
        bif.M0_address = v.m0_addr;
        bif.M0_dout    = v.m0_dout;
        bif.M1_req     = v.m1_req;
        bif.M1_wr      = v.m1_wr;
        bif.M1_address = v.m1_addr;
        bif.M1_dout    = v.m1_dout;
        bif.S0_dout    = v.s0_dout;
        bif.S1_dout    = v.s1_dout;
    endtask

    initial begin
        logic exp_sw;
        n_tests = 0;
        n_fail  = 0;

        //          m0 req wr addr   dout   m1 req wr addr   dout   s0     s1     ctl       addr   din    mdin
        vecs[0] = '{1'b1, 1'b1, 8'h05, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 8'h11, 8'h22, 5'b10101, 8'h05, 8'hA5, 8'h11};
        vecs[1] = '{1'b0, 1'b0, 8'h05, 8'hA5, 1'b1, 1'b0, 8'h21, 8'h77, 8'h11, 8'h3C, 5'b01010, 8'h21, 8'h77, 8'h3C};
        vecs[2] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h21, 8'h77, 8'h11, 8'h3C, 5'b01010, 8'h21, 8'h77, 8'h3C};
        vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h21, 8'h77, 8'h5A, 8'h3C, 5'b10100, 8'h10, 8'h00, 8'h5A};
        vecs[4] = '{1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 8'h21, 8'h77, 8'h5A, 8'h3C, 5'b10000, 8'h80, 8'h00, 8'h00};
        vecs[5] = '{1'b0, 1'b1, 8'h05, 8'hA5, 1'b0, 1'b0, 8'h21, 8'h77, 8'h5A, 8'h3C, 5'b10000, 8'h05, 8'hA5, 8'h00};
        vecs[6] = '{1'b1, 1'b1, 8'h3F, 8'hC3, 1'b1, 1'b0, 8'h00, 8'h00, 8'h5A, 8'h66, 5'b10011, 8'h3F, 8'hC3, 8'h66};
        vecs[7] = '{1'b0, 1'b1, 8'h3F, 8'hC3, 1'b1, 1'b1, 8'h00, 8'h99, 8'h5A, 8'h66, 5'b01101, 8'h00, 8'h99, 8'h5A};
        vecs[8] = '{1'b0, 1'b0, 8'h3F, 8'hC3, 1'b0, 1'b1, 8'h00, 8'h99, 8'h5A, 8'h66, 5'b01000, 8'h00, 8'h99, 8'h00};
        vecs[9] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h99, 8'h5A, 8'h66, 5'b10100, 8'h05, 8'h00, 8'h5A};

        // Reset held, M0 idle: grant parks on M0, selects and strobe low.
        reset = 1'b1;
        drive('{1'b0, 1'b1, 8'h05, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 8'h11, 8'h22, 5'b0, 8'h0, 8'h0, 8'h0});
        #1;
        check("reset_grant", {30'd0, bif.M0_grant, bif.M1_grant}, 32'h2);
        check("reset_bus_error", {31'd0, bif.bus_error}, 32'h0);
        check("reset_idle_sel_wr", {29'd0, bif.S0_sel, bif.S1_sel, bif.S_wr}, 32'h0);

        // M0 write to slave 0 is visible combinationally while still in reset.
        bif.M0_req = 1'b1;
        #1;
        check("reset_m0_write", {13'd0, bif.S0_sel, bif.S1_sel, bif.S_wr, bif.S_address, bif.S_din},
              {13'd0, 1'b1, 1'b0, 1'b1, 8'h05, 8'hA5});
        #10;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {3'd0, bif.M0_grant, bif.M1_grant, bif.S0_sel, bif.S1_sel, bif.S_wr,
                   bif.S_address, bif.S_din, bif.M_din},
                  {3'd0, vecs[i].e_ctl, vecs[i].e_addr, vecs[i].e_din, vecs[i].e_mdin});
            check($sformatf("vec%0d_bus_error", i), {31'd0, bif.bus_error}, 32'h0);
        end

        // M0 owns and holds req while M1 keeps requesting.
        bif.M1_req     = 1'b1;
        bif.M1_wr      = 1'b0;
        bif.M1_address = 8'h21;
        bif.S1_dout    = 8'h3C;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
`ifdef BUS_TIMEOUT_EN
            exp_sw = (c == 16);
`else
            exp_sw = 1'b0;
`endif
            check($sformatf("hold%0d_grant", c), {30'd0, bif.M0_grant, bif.M1_grant},
                  {30'd0, ~exp_sw, exp_sw});
            check($sformatf("hold%0d_bus_error", c), {31'd0, bif.bus_error}, {31'd0, exp_sw});
        end

        // M0 releases: either way M1 now owns, and any error pulse has ended.
        bif.M0_req = 1'b0;
        @(posedge clk);
        #1;
        check("post_hold_grant", {30'd0, bif.M0_grant, bif.M1_grant}, 32'h1);
        check("post_hold_bus_error", {31'd0, bif.bus_error}, 32'h0);
        check("m1_read_data", {22'd0, bif.S1_sel, bif.S0_sel, bif.M_din}, {22'd0, 1'b1, 1'b0, 8'h3C});

        // Asynchronous reset mid-read, sampled before any clock edge.
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_grant", {30'd0, bif.M0_grant, bif.M1_grant}, 32'h2);
        check("async_reset_bus_error", {31'd0, bif.bus_error}, 32'h0);
        check("async_reset_sel_wr", {29'd0, bif.S0_sel, bif.S1_sel, bif.S_wr}, 32'h0);
        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("after_reset_m1_regrant", {30'd0, bif.M0_grant, bif.M1_grant}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter S0_BASE, 8'h00, slave 0 (memory) base address.
REQ-002 Parameter S1_BASE, 8'h20, slave 1 (timer register file) base address.
REQ-003 Parameter DEC_MASK, 8'hE0, decode mask; slave n hits when (address & DEC_MASK) == Sn_BASE.
REQ-004 Parameter TIMEOUT_CYCLES, 16, contended-hold limit, used only when BUS_TIMEOUT_EN is defined.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 M0_req / M0_wr  input  1 / 1  master 0 (test master) request and write strobe.
REQ-008 M0_address / M0_dout  input  8 / 8  master 0 address and write data.
REQ-009 M1_req / M1_wr  input  1 / 1  master 1 (timer master port) request and write strobe.
REQ-010 M1_address / M1_dout  input  8 / 8  master 1 address and write data.
REQ-011 M0_grant / M1_grant  output  1 / 1  registered grants, exactly one high at all times.
REQ-012 M_din  output  8  read data returned to both masters.
REQ-013 S0_sel / S1_sel  output  1 / 1  slave selects.
REQ-014 S_address / S_wr / S_din  output  8 / 1 / 8  muxed address, write strobe, write data to slaves.
REQ-015 S0_dout / S1_dout  input  8 / 8  slave read data.
REQ-016 bus_error  output  1  one-cycle pulse on forced grant revocation.

Function
REQ-017 Arbiter SHALL be a two-state FSM: GNT_M0, GNT_M1; M0_grant = (state==GNT_M0), M1_grant = (state==GNT_M1).
REQ-018 GNT_M0 -> GNT_M1 when M0_req==0 and M1_req==1; otherwise stay; GNT_M1 -> GNT_M0 symmetrically.
REQ-019 Grant SHALL park on last owner when neither master requests; owner holding req keeps bus (no preemption except REQ-027).
REQ-020 Grant latency: request to idle bus from non-owner -> grant high on the next rising edge (1 cycle).
REQ-021 Simultaneous M0_req and M1_req with owner not requesting: switch to the other master; owner requesting: stay.
REQ-022 S_address, S_wr, S_din SHALL be combinationally muxed from the granted master.
REQ-023 Sn_sel = granted master's req AND address decode hit for slave n; at most one select high.
REQ-024 S_wr SHALL be 0 when granted master's req is 0.
REQ-025 M_din = S0_dout if S0_sel, else S1_dout if S1_sel, else 8'h00 (unmapped address reads zero, writes dropped).
REQ-026 A request to an address hitting neither slave SHALL still hold grant normally; no error raised.

Reset
REQ-027 On reset high, immediately: state=GNT_M0 (M0_grant=1, M1_grant=0), bus_error=0, timeout counter=0; reset mid-transfer aborts it with no held state.
REQ-028 S*_sel, S_wr SHALL follow REQ-023/024 from GNT_M0 during reset (low when M0_req low).

Configuration
REQ-029 Macro BUS_TIMEOUT_EN defined: counter increments each cycle owner holds req while the other master requests, clears otherwise; on reaching TIMEOUT_CYCLES grant SHALL switch on that edge, counter clears, bus_error pulses high one cycle.
REQ-030 Macro BUS_TIMEOUT_EN undefined: no counter logic, no forced switch, bus_error tied 0; port list unchanged.

Verification
REQ-031 Reset, M0_req=1 addr 8'h05 wr=1 din 8'hA5 -> M0_grant=1 immediately, S0_sel=1, S_wr=1, S_din=8'hA5, S1_sel=0.
REQ-032 M0 idle, M1_req=1 addr 8'h21 wr=0, S1_dout=8'h3C -> M1_grant=1 one edge later, S1_sel=1, M_din=8'h3C.
REQ-033 M1 owns and holds req, M0_req raised -> M0_grant stays 0 until M1_req drops, then M0_grant=1 next edge.
REQ-034 Granted M0 reads addr 8'h80 -> S0_sel=S1_sel=0, M_din=8'h00.
REQ-035 BUS_TIMEOUT_EN defined, M0 holds req and M1 requests 16 cycles -> grant switches to M1 on 16th edge, bus_error high exactly one cycle; undefined -> M0 keeps grant, bus_error stays 0.
REQ-036 Assert reset while M1 granted mid-read -> M0_grant=1, M1_grant=0, bus_error=0 without a clock edge.
